// File: rtl/spike_decoder.sv
// spike_decoder: receiving end of a neuron spike link.
// Rebuilds a 4-bit leaky synaptic current from the incoming spike train.
// Counts spikes over fixed back-to-back windows. Each window result is
// offered on a valid/ready handshake, and a sticky overrun flag records
// any result that had to be dropped.
module spike_decoder #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike_in,
  input  logic [3:0]       weight,
  output logic [3:0]       current_out,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } hs_state_t;

  // Synaptic current path
  logic [3:0]       syn_r;
  logic [4:0]       sum_s;
  logic [3:0]       syn_nxt_s;

  // Window counting
  logic [WIN_W-1:0] win_cnt_r;
  logic [WIN_W-1:0] win_cnt_nxt_s;
  logic [CNT_W-1:0] spk_cnt_r;
  logic [CNT_W-1:0] spk_cnt_nxt_s;
  logic [CNT_W-1:0] final_cnt_s;
  logic             close_s;

  // Handshake
  hs_state_t        state_r;
  hs_state_t        state_nxt_s;
  logic             xfer_s;
  logic [CNT_W-1:0] rate_r;
  logic [CNT_W-1:0] rate_nxt_s;
  logic             overrun_r;
  logic             overrun_nxt_s;

  // Leaky integration: halve the old current, add the weight on a spike, clamp at 15
  always_comb begin
    sum_s     = 5'd0;
    syn_nxt_s = 4'd0;
    if (spike_in) begin
      sum_s = {2'b00, syn_r[3:1]} + {1'b0, weight};
    end else begin
      sum_s = {2'b00, syn_r[3:1]};
    end
    if (sum_s > 5'd15) begin
      syn_nxt_s = 4'd15;
    end else begin
      syn_nxt_s = sum_s[3:0];
    end
  end

  // Synaptic current register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syn_r <= 4'd0;
    end else begin
      syn_r <= syn_nxt_s;
    end
  end

  // Window close detection and saturating spike count including this edge's spike
  always_comb begin
    close_s       = (win_cnt_r == WIN_LAST);
    final_cnt_s   = spk_cnt_r;
    win_cnt_nxt_s = win_cnt_r;
    spk_cnt_nxt_s = spk_cnt_r;
    if (spike_in && (spk_cnt_r != CNT_MAX)) begin
      final_cnt_s = spk_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      final_cnt_s = spk_cnt_r;
    end
    if (close_s) begin
      win_cnt_nxt_s = {WIN_W{1'b0}};
      spk_cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      win_cnt_nxt_s = win_cnt_r + {{(WIN_W-1){1'b0}}, 1'b1};
      spk_cnt_nxt_s = final_cnt_s;
    end
  end

  // Window and spike counters; windows never stall on back-pressure
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt_r <= {WIN_W{1'b0}};
      spk_cnt_r <= {CNT_W{1'b0}};
    end else begin
      win_cnt_r <= win_cnt_nxt_s;
      spk_cnt_r <= spk_cnt_nxt_s;
    end
  end

  assign xfer_s = (state_r == ST_VALID) && rate_ready;

  // Handshake state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Handshake next state: a close while VALID keeps VALID whether the new result is loaded or dropped
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (close_s) begin
          state_nxt_s = ST_VALID;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_VALID: begin
        if (xfer_s && !close_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_VALID;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs: load a result when the slot is free or freed this edge, else flag overrun
  always_comb begin
    rate_nxt_s    = rate_r;
    overrun_nxt_s = overrun_r;
    case (state_r)
      ST_IDLE: begin
        if (close_s) begin
          rate_nxt_s = final_cnt_s;
        end else begin
          rate_nxt_s = rate_r;
        end
      end
      ST_VALID: begin
        if (close_s && xfer_s) begin
          rate_nxt_s = final_cnt_s;
        end else if (close_s) begin
          overrun_nxt_s = 1'b1;
        end else begin
          rate_nxt_s = rate_r;
        end
      end
      default: begin
        rate_nxt_s    = rate_r;
        overrun_nxt_s = overrun_r;
      end
    endcase
  end

  // Result and sticky overrun registers; overrun clears only on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rate_r    <= {CNT_W{1'b0}};
      overrun_r <= 1'b0;
    end else begin
      rate_r    <= rate_nxt_s;
      overrun_r <= overrun_nxt_s;
    end
  end

  assign current_out = syn_r;
  assign rate_out    = rate_r;
  assign rate_valid  = (state_r == ST_VALID);
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_spike_decoder.sv
// Directed self-checking bench for spike_decoder (WINDOW=16, CNT_W=5).
module tb_spike_decoder;

  logic       clk;
  logic       reset;
  logic       spike_in;
  logic [3:0] weight;
  logic [3:0] current_out;
  logic [4:0] rate_out;
  logic       rate_valid;
  logic       rate_ready;
  logic       overrun;

  int checks;
  int errors;

  spike_decoder #(.WINDOW(16), .CNT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .spike_in   (spike_in),
    .weight     (weight),
    .current_out(current_out),
    .rate_out   (rate_out),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset held across an edge, released mid-cycle; first edge afterwards is edge 1
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    spike_in   = 1'b0;
    weight     = 4'd0;
    rate_ready = 1'b0;
    #2;
    chk("rst_current", current_out, 0);
    chk("rst_valid", rate_valid, 0);
    chk("rst_rate", rate_out, 0);
    chk("rst_overrun", overrun, 0);
    step();
    reset = 1'b0;

    // Decay: one spike of weight 8 then halving
    weight   = 4'd8;
    spike_in = 1'b1;
    step();
    chk("decay_e1", current_out, 8);
    spike_in = 1'b0;
    step(); chk("decay_e2", current_out, 4);
    step(); chk("decay_e3", current_out, 2);
    step(); chk("decay_e4", current_out, 1);
    step(); chk("decay_e5", current_out, 0);

    // Saturation
    do_reset();
    weight   = 4'd15;
    spike_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_15", current_out, 15);
    end
    weight = 4'd3;
    step(); chk("sat_w3_a", current_out, 10);
    step(); chk("sat_w3_b", current_out, 8);

    // Rate readout with ready held high: spikes on edges 1,3,5,7,9
    do_reset();
    weight     = 4'd0;
    rate_ready = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      spike_in = (e <= 9) && (e % 2 == 1);
      step();
    end
    chk("rd_valid_e15", rate_valid, 0);
    spike_in = 1'b0;
    step();
    chk("rd_valid_e16", rate_valid, 1);
    chk("rd_rate_e16", rate_out, 5);
    step();
    chk("rd_valid_e17", rate_valid, 0);
    chk("rd_overrun", overrun, 0);

    // Back-pressure: 5 spikes in window 1, 3 in window 2, ready low
    do_reset();
    rate_ready = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      spike_in = (e <= 5) || (e >= 17 && e <= 19);
      step();
      if (e == 16) begin
        chk("bp_valid_e16", rate_valid, 1);
        chk("bp_rate_e16", rate_out, 5);
        chk("bp_overrun_e16", overrun, 0);
      end
    end
    spike_in = 1'b0;
    chk("bp_rate_e32", rate_out, 5);
    chk("bp_valid_e32", rate_valid, 1);
    chk("bp_overrun_e32", overrun, 1);
    rate_ready = 1'b1;
    step();
    rate_ready = 1'b0;
    chk("bp_valid_e33", rate_valid, 0);
    chk("bp_overrun_e33", overrun, 1);

    // Simultaneous transfer and close on edge 32: window 2 has 7 spikes
    do_reset();
    for (int e = 1; e <= 32; e++) begin
      spike_in   = (e <= 5) || (e >= 17 && e <= 23);
      rate_ready = (e == 32);
      step();
      if (e == 31) begin
        chk("sim_rate_e31", rate_out, 5);
      end
    end
    spike_in   = 1'b0;
    rate_ready = 1'b0;
    chk("sim_rate_e32", rate_out, 7);
    chk("sim_valid_e32", rate_valid, 1);
    chk("sim_overrun_e32", overrun, 0);
    step();
    chk("sim_valid_e33", rate_valid, 1);
    chk("sim_rate_e33", rate_out, 7);

    // Reset mid-operation: syn=12 with a result pending, reset between edges
    weight   = 4'd12;
    spike_in = 1'b1;
    step();
    spike_in = 1'b0;
    chk("mid_current_pre", current_out, 12);
    chk("mid_valid_pre", rate_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_current", current_out, 0);
    chk("mid_rate", rate_out, 0);
    chk("mid_valid", rate_valid, 0);
    chk("mid_overrun", overrun, 0);
    step();
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
